// File: rtl/csr_access_unit.sv
// Zicsr execution unit: read-modify-write sequencer sitting directly in front of csr_file.
// Accepts one CSRRW/CSRRS/CSRRC request at a time and returns the pre-access CSR value.
module csr_access_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_src,
    input  logic              req_src_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_illegal,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_din,
    output logic              csr_write_en,
    input  logic [XLEN-1:0]   csr_dout
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   src_q;
    logic              src_zero_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   din_q;
    logic              wen_q;
    logic              rsp_valid_q;
    logic              illegal_q;

    logic [XLEN-1:0]   new_val;
    logic              wr_needed;
    logic              addr_known;
    logic              read_only;
    logic              illegal_acc;

    always_comb begin
        new_val = '0;
        unique case (op_q)
            OP_RW:   new_val = src_q;
            OP_RS:   new_val = csr_dout | src_q;
            OP_RC:   new_val = csr_dout & ~src_q;
            default: new_val = '0;
        endcase
    end

    always_comb begin
        addr_known = (addr_q == ADDR_W'(12'h300))
                   | (addr_q == ADDR_W'(12'h304))
                   | (addr_q == ADDR_W'(12'h305))
                   | (addr_q == ADDR_W'(12'h340))
                   | (addr_q == ADDR_W'(12'h341))
                   | (addr_q == ADDR_W'(12'h342))
                   | (addr_q == ADDR_W'(12'h344));
        // Top two address bits == 11 mark the read-only CSR space.
        read_only   = (addr_q[ADDR_W-1 -: 2] == 2'b11);
        wr_needed   = (op_q == OP_RW) | ~src_zero_q;
        illegal_acc = (op_q == 2'b00) | ~addr_known
                    | (wr_needed & read_only);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            src_q       <= '0;
            src_zero_q  <= 1'b0;
            old_q       <= '0;
            din_q       <= '0;
            wen_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        addr_q     <= req_addr;
                        src_q      <= req_src;
                        src_zero_q <= req_src_zero;
                        illegal_q  <= 1'b0;
                        state_q    <= READ;
                    end
                end
                READ: begin
                    if (illegal_acc) begin
                        old_q       <= '0;
                        illegal_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (wr_needed) begin
                        old_q   <= csr_dout;
                        din_q   <= new_val;
                        wen_q   <= 1'b1;
                        state_q <= WRITE;
                    end else begin
                        old_q       <= csr_dout;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                WRITE: begin
                    din_q       <= '0;
                    wen_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset must kill a write in flight within the same cycle.
    assign csr_write_en = wen_q & ~rst;
    assign req_ready    = (state_q == IDLE) & ~rst;
    assign csr_addr     = addr_q;
    assign csr_din      = din_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = old_q;
    assign rsp_illegal  = illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed Zicsr scenarios plus randomized accesses
// checked against an array-based model of the machine-mode CSR file.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        req_src_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_illegal;
    logic [11:0] csr_addr;
    logic [31:0] csr_din;
    logic        csr_write_en;
    logic [31:0] csr_dout;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    csr_access_unit #(.XLEN(32), .ADDR_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_src      (req_src),
        .req_src_zero (req_src_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_illegal  (rsp_illegal),
        .csr_addr     (csr_addr),
        .csr_din      (csr_din),
        .csr_write_en (csr_write_en),
        .csr_dout     (csr_dout)
    );

    // Environment: csr_file with combinational read and a preload port.
    logic [31:0] csr_mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          wr_count = 0;
    logic [31:0] last_din = '0;

    assign csr_dout = csr_mem[csr_addr];

    always @(posedge clk) begin
        if (pl_en) begin
            csr_mem[pl_addr] <= pl_data;
        end else if (csr_write_en) begin
            csr_mem[csr_addr] <= csr_din;
            wr_count <= wr_count + 1;
            last_din <= csr_din;
        end
    end

    function automatic bit is_known(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340,
                         12'h341, 12'h342, 12'h344};
    endfunction

    // Reference: applies the Zicsr rules and updates the model CSR file.
    task automatic predict(input logic [1:0] op, input logic [11:0] a,
                           input logic [31:0] src, input logic sz,
                           output logic [31:0] old, output logic ill,
                           output logic wr, output logic [31:0] nv);
        logic wants;
        wants = (op == 2'd1) || !sz;
        ill = (op == 2'd0) || !is_known(a) || (wants && a[11:10] == 2'b11);
        old = ill ? 32'h0 : ref_mem[a];
        case (op)
            2'd1:    nv = src;
            2'd2:    nv = old | src;
            default: nv = old & ~src;
        endcase
        wr = !ill && wants;
        if (wr) ref_mem[a] = nv;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Issues one request; lat counts edges from the accept edge to rsp_valid.
    task automatic do_access(input logic [1:0] op, input logic [11:0] a,
                             input logic [31:0] src, input logic sz,
                             output int lat, output logic [31:0] data,
                             output logic ill, output int nwr,
                             output logic [31:0] din);
        int w0;
        w0 = wr_count;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a;
        req_src = src; req_src_zero = sz;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = 99;
        data = rsp_data;
        ill  = rsp_illegal;
        nwr  = wr_count - w0;
        din  = last_din;
        if (rsp_ready) @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0;
        req_src = '0; req_src_zero = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        vecs++;
        if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        vecs++;
        if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        vecs++;
        if (rsp_illegal !== 1'b0) begin errs++; $display("FAIL rst_rsp_illegal: got %b want 0", rsp_illegal); end
        vecs++;
        if (rsp_data !== 32'h0) begin errs++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        vecs++;
        if (csr_write_en !== 1'b0) begin errs++; $display("FAIL rst_write_en: got %b want 0", csr_write_en); end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_rw;
        logic [31:0] eo, en, d, dn; logic ei, ew, il; int lat, nw;
        preload(12'h340, 32'h12345678);
        predict(2'd1, 12'h340, 32'hDEADBEEF, 1'b0, eo, ei, ew, en);
        do_access(2'd1, 12'h340, 32'hDEADBEEF, 1'b0, lat, d, il, nw, dn);
        vecs++;
        if (lat !== 3) begin errs++; $display("FAIL rw_latency: got %0d want 3", lat); end
        vecs++;
        if (nw !== 1) begin errs++; $display("FAIL rw_pulses: got %0d want 1", nw); end
        vecs++;
        if (dn !== 32'hDEADBEEF) begin errs++; $display("FAIL rw_din: got %h want deadbeef", dn); end
        vecs++;
        if (d !== 32'h12345678) begin errs++; $display("FAIL rw_data: got %h want 12345678", d); end
        vecs++;
        if (il !== 1'b0) begin errs++; $display("FAIL rw_illegal: got %b want 0", il); end
        vecs++;
        if (csr_mem[12'h340] !== ref_mem[12'h340]) begin
            errs++; $display("FAIL rw_mem: got %h want %h", csr_mem[12'h340], ref_mem[12'h340]);
        end
    endtask

    task automatic test_set_clear;
        logic [31:0] eo, en, d, dn; logic ei, ew, il; int lat, nw;
        preload(12'h300, 32'h08);
        predict(2'd2, 12'h300, 32'h80, 1'b0, eo, ei, ew, en);
        do_access(2'd2, 12'h300, 32'h80, 1'b0, lat, d, il, nw, dn);
        vecs++;
        if (dn !== 32'h88 || nw !== 1) begin errs++; $display("FAIL rs_din: got %h/%0d want 88/1", dn, nw); end
        vecs++;
        if (d !== 32'h08) begin errs++; $display("FAIL rs_data: got %h want 08", d); end
        predict(2'd3, 12'h300, 32'h08, 1'b0, eo, ei, ew, en);
        do_access(2'd3, 12'h300, 32'h08, 1'b0, lat, d, il, nw, dn);
        vecs++;
        if (dn !== 32'h80 || nw !== 1) begin errs++; $display("FAIL rc_din: got %h/%0d want 80/1", dn, nw); end
        vecs++;
        if (d !== 32'h88) begin errs++; $display("FAIL rc_data: got %h want 88", d); end
    endtask

    task automatic test_src_zero;
        logic [31:0] eo, en, d, dn; logic ei, ew, il; int lat, nw;
        preload(12'h305, 32'h0000_0100);
        predict(2'd2, 12'h305, 32'h0, 1'b1, eo, ei, ew, en);
        do_access(2'd2, 12'h305, 32'h0, 1'b1, lat, d, il, nw, dn);
        vecs++;
        if (nw !== 0) begin errs++; $display("FAIL rsz_pulses: got %0d want 0", nw); end
        vecs++;
        if (lat !== 2) begin errs++; $display("FAIL rsz_latency: got %0d want 2", lat); end
        vecs++;
        if (d !== eo) begin errs++; $display("FAIL rsz_data: got %h want %h", d, eo); end
    endtask

    task automatic test_illegal;
        logic [31:0] d, dn; int lat, nw; logic il;
        do_access(2'd1, 12'hC00, 32'h5, 1'b0, lat, d, il, nw, dn);
        vecs++;
        if (il !== 1'b1 || d !== 32'h0) begin errs++; $display("FAIL ill_ro: got %b/%h want 1/0", il, d); end
        vecs++;
        if (nw !== 0) begin errs++; $display("FAIL ill_ro_wen: got %0d want 0", nw); end
        do_access(2'd0, 12'h300, 32'hFF, 1'b0, lat, d, il, nw, dn);
        vecs++;
        if (il !== 1'b1 || d !== 32'h0) begin errs++; $display("FAIL ill_op: got %b/%h want 1/0", il, d); end
        vecs++;
        if (nw !== 0) begin errs++; $display("FAIL ill_op_wen: got %0d want 0", nw); end
        vecs++;
        if (csr_mem[12'h300] !== ref_mem[12'h300]) begin
            errs++; $display("FAIL ill_op_mem: got %h want %h", csr_mem[12'h300], ref_mem[12'h300]);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] eo, en, d, dn; logic ei, ew, il; int lat, nw, w0;
        preload(12'h304, 32'h0000_A5A5);
        rsp_ready = 1'b0;
        predict(2'd1, 12'h304, 32'h1, 1'b0, eo, ei, ew, en);
        do_access(2'd1, 12'h304, 32'h1, 1'b0, lat, d, il, nw, dn);
        w0 = wr_count;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 1);
            req_op = 2'd1; req_addr = 12'h340; req_src = 32'h0; req_src_zero = 1'b1;
            @(negedge clk);
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_data !== eo || rsp_illegal !== 1'b0) begin
                errs++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", i, rsp_valid, rsp_data, eo);
            end
            vecs++;
            if (req_ready !== 1'b0) begin errs++; $display("FAIL bp_ready[%0d]: got %b want 0", i, req_ready); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        vecs++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errs++; $display("FAIL bp_release: got valid %b ready %b want 0 1", rsp_valid, req_ready);
        end
        vecs++;
        if (wr_count !== w0 || csr_mem[12'h340] !== ref_mem[12'h340]) begin
            errs++; $display("FAIL bp_ignored: got %0d writes want 0", wr_count - w0);
        end
    endtask

    task automatic test_reset_in_write;
        int w0; bit seen;
        preload(12'h341, 32'hCAFEF00D);
        w0 = wr_count;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_addr = 12'h341;
        req_src = 32'h1111_1111; req_src_zero = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        vecs++;
        if (csr_write_en !== 1'b0 || req_ready !== 1'b0) begin
            errs++; $display("FAIL rstw_gate: got wen %b ready %b want 0 0", csr_write_en, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vecs++;
        if (csr_mem[12'h341] !== ref_mem[12'h341] || wr_count !== w0) begin
            errs++; $display("FAIL rstw_mepc: got %h want %h", csr_mem[12'h341], ref_mem[12'h341]);
        end
        vecs++;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL rstw_idle: got %b want 1", req_ready); end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        vecs++;
        if (seen !== 1'b0) begin errs++; $display("FAIL rstw_no_rsp: got %b want 0", seen); end
    endtask

    task automatic test_random;
        logic [11:0] legal [7];
        logic [31:0] eo, en, d, dn, src; logic ei, ew, il, sz;
        logic [1:0] op; logic [11:0] a; int lat, nw, el;
        legal = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344};
        for (int i = 0; i < 7; i++) preload(legal[i], $urandom);
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = 12'hC00 | 12'($urandom_range(0, 255));
                1:       a = 12'($urandom);
                default: a = legal[$urandom_range(0, 6)];
            endcase
            sz  = ($urandom_range(0, 3) == 0);
            src = sz ? 32'h0 : $urandom;
            predict(op, a, src, sz, eo, ei, ew, en);
            el = ew ? 3 : 2;
            do_access(op, a, src, sz, lat, d, il, nw, dn);
            vecs++;
            if (d !== eo || il !== ei) begin
                errs++; $display("FAIL rnd[%0d] rsp: op %0d addr %h got %h/%b want %h/%b", i, op, a, d, il, eo, ei);
            end
            vecs++;
            if (lat !== el || nw !== (ew ? 1 : 0)) begin
                errs++; $display("FAIL rnd[%0d] timing: got lat %0d wr %0d want %0d %0d", i, lat, nw, el, ew);
            end
            if (ew) begin
                vecs++;
                if (dn !== en) begin errs++; $display("FAIL rnd[%0d] din: got %h want %h", i, dn, en); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_rw;
        test_set_clear;
        test_src_zero;
        test_illegal;
        test_backpressure;
        test_reset_in_write;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
